// File: rtl/cp0_pkg.sv
// Shared definitions for the cp0 block: register numbers, field positions and SR layout.
package cp0_pkg;

  localparam logic [31:0] PRID = 32'h0000_0131;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int unsigned IM_LSB  = 10;
  localparam int unsigned IM_MSB  = 15;
  localparam int unsigned IP_LSB  = 10;
  localparam int unsigned IP_MSB  = 15;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned TI_BIT  = 30;

  // Only the architecturally implemented SR bits are stored.
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  function automatic logic [31:0] sr_to_word(sr_t sr);
    logic [31:0] w;
    w                = '0;
    w[IM_MSB:IM_LSB] = sr.im;
    w[EXL_BIT]       = sr.exl;
    w[IE_BIT]        = sr.ie;
    return w;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Bus between the multicycle controller/datapath (master) and cp0 (slave).
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic [31:0] PC;
  logic [5:0]  HWInt;
  logic        We;
  logic        EXLSet;
  logic        EXLClr;
  logic        intreq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, PC, HWInt, We, EXLSet, EXLClr,
    input  intreq, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, PC, HWInt, We, EXLSet, EXLClr,
    output intreq, EPC, DOut
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer for cp0; TI is a sticky match flag cleared by writing Compare.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_count_i,
  input  logic        we_compare_i,
  input  logic [31:0] din_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d, compare_q, compare_d, count_inc;
  logic        ti_q, ti_d;

  assign count_inc = count_q + 32'd1;

  // Next-state: a Count write beats the increment; a Compare write beats a match.
  always_comb begin
    count_d   = we_count_i ? din_i : count_inc;
    compare_d = we_compare_i ? din_i : compare_q;
    ti_d      = ti_q;
    if (!we_count_i && (count_inc == compare_q)) ti_d = 1'b1;
    if (we_compare_i) ti_d = 1'b0;
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC, PRId and interrupt request generation.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0 (
  input  logic clk,
  input  logic rst,
  cp0_if.slave bus
);
  import cp0_pkg::*;

  sr_t         sr_q, sr_d;
  logic [5:0]  ip_q;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  ip_eff;
  logic        ti;
  logic [31:0] dout;
  logic        wr_sr, wr_epc;
  logic        unused_pc;

  assign wr_sr     = bus.We && (bus.A2 == CP0_SR);
  assign wr_epc    = bus.We && (bus.A2 == CP0_EPC);
  assign unused_pc = ^bus.PC[1:0];

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .we_count_i   (bus.We && (bus.A2 == CP0_COUNT)),
    .we_compare_i (bus.We && (bus.A2 == CP0_COMPARE)),
    .din_i        (bus.DIn),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );
`else
  assign ti = 1'b0;
`endif

  // TI shares the HWInt[5] slot so IM[15] masks it.
  assign ip_eff = ip_q | {ti, 5'b0};

  // Next-state for SR and EPC: EXLSet > EXLClr > mtc0 on EXL, EXLSet > mtc0 on EPC.
  always_comb begin
    sr_d  = sr_q;
    epc_d = epc_q;
    if (wr_sr) begin
      sr_d.im  = bus.DIn[IM_MSB:IM_LSB];
      sr_d.exl = bus.DIn[EXL_BIT];
      sr_d.ie  = bus.DIn[IE_BIT];
    end
    if (wr_epc) epc_d = {bus.DIn[31:2], 2'b00};
    if (bus.EXLClr) sr_d.exl = 1'b0;
    if (bus.EXLSet) begin
      sr_d.exl = 1'b1;
      epc_d    = {bus.PC[31:2], 2'b00};
    end
  end

  // State registers; IP simply tracks the level-sensitive lines each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      ip_q  <= '0;
      epc_q <= '0;
    end else begin
      sr_q  <= sr_d;
      ip_q  <= bus.HWInt;
      epc_q <= epc_d;
    end
  end

  // Combinational mfc0 read port; unmapped numbers read zero.
  always_comb begin
    dout = '0;
    case (bus.A1)
      CP0_SR:    dout = sr_to_word(sr_q);
      CP0_CAUSE: begin
        dout[IP_MSB:IP_LSB] = ip_eff;
        dout[TI_BIT]        = ti;
      end
      CP0_EPC:   dout = epc_q;
      CP0_PRID:  dout = PRID;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   dout = count;
      CP0_COMPARE: dout = compare;
`endif
      default:   dout = '0;
    endcase
  end

  assign bus.intreq = (|(ip_eff & sr_q.im)) & sr_q.ie & ~sr_q.exl;
  assign bus.EPC    = epc_q;
  assign bus.DOut   = dout;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus random traffic against a register model.
module tb_cp0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_if bus();

  cp0 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nchecks = 0;
  int nerrors = 0;

  // Architectural model of the visible registers.
  logic [31:0] m_sr, m_epc, m_count, m_compare;
  logic [5:0]  m_ip;
  logic        m_ti;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [5:0] ipe;
    ipe = m_ip | {m_ti, 5'b0};
    case (a)
      5'd12: return m_sr;
      5'd13: return {1'b0, m_ti, 14'b0, ipe, 10'b0};
      5'd14: return m_epc;
      5'd15: return 32'h0000_0131;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_intreq();
    logic [5:0] ipe;
    ipe = m_ip | {m_ti, 5'b0};
    return ((ipe & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
  endfunction

  // Apply one clock edge's worth of architectural rules using the inputs now on the bus.
  task automatic model_edge();
    if (rst) begin
      m_sr = 0; m_epc = 0; m_count = 0; m_compare = 0; m_ip = 0; m_ti = 0;
    end else begin
      m_ip = bus.HWInt;
      if (bus.We && bus.A2 == 5'd12) m_sr = bus.DIn & 32'h0000_FC03;
      if (bus.We && bus.A2 == 5'd14) m_epc = bus.DIn & ~32'h3;
      if (bus.EXLClr) m_sr[1] = 1'b0;
      if (bus.EXLSet) begin
        m_sr[1] = 1'b1;
        m_epc   = bus.PC & ~32'h3;
      end
`ifdef CP0_TIMER_EN
      if (bus.We && bus.A2 == 5'd9) m_count = bus.DIn;
      else begin
        m_count = m_count + 1;
        if (m_count == m_compare) m_ti = 1'b1;
      end
      if (bus.We && bus.A2 == 5'd11) begin
        m_compare = bus.DIn;
        m_ti      = 1'b0;
      end
`endif
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.We = 1'b1; bus.A2 = a; bus.DIn = d;
    tick();
    bus.We = 1'b0; bus.A2 = 5'd0; bus.DIn = 32'h0;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [4];
    logic [31:0] exps  [4];
    addrs = '{5'd12, 5'd13, 5'd14, 5'd15};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h0000_0131};
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nchecks++;
    if (bus.intreq !== 1'b0) begin
      nerrors++; $display("FAIL reset_intreq got %b exp 0", bus.intreq);
    end
    nchecks++;
    if (bus.EPC !== 32'h0) begin
      nerrors++; $display("FAIL reset_epc got %h exp 0", bus.EPC);
    end
    for (int i = 0; i < 4; i++) begin
      bus.A1 = addrs[i];
      #1;
      nchecks++;
      if (bus.DOut !== exps[i]) begin
        nerrors++; $display("FAIL reset_read%0d got %h exp %h", addrs[i], bus.DOut, exps[i]);
      end
    end
  endtask

  task automatic test_intr();
    wr(5'd12, 32'h0000_0401);
    bus.HWInt = 6'b000001;
    #1;
    nchecks++;
    if (bus.intreq !== 1'b0) begin
      nerrors++; $display("FAIL intr_before_edge got %b exp 0", bus.intreq);
    end
    tick();
    nchecks++;
    if (bus.intreq !== 1'b1) begin
      nerrors++; $display("FAIL intr_raise got %b exp 1", bus.intreq);
    end
    bus.EXLSet = 1'b1; bus.PC = 32'h0000_3010;
    tick();
    bus.EXLSet = 1'b0;
    nchecks++;
    if (bus.EPC !== 32'h0000_3010) begin
      nerrors++; $display("FAIL exlset_epc got %h exp 00003010", bus.EPC);
    end
    nchecks++;
    if (bus.intreq !== 1'b0) begin
      nerrors++; $display("FAIL exlset_intreq got %b exp 0", bus.intreq);
    end
    bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    nchecks++;
    if (bus.intreq !== 1'b1) begin
      nerrors++; $display("FAIL exlclr_intreq got %b exp 1", bus.intreq);
    end
    bus.HWInt = 6'b0;
    tick();
    nchecks++;
    if (bus.intreq !== 1'b0) begin
      nerrors++; $display("FAIL hwint_drop got %b exp 0", bus.intreq);
    end
  endtask

  task automatic test_mask();
    bus.HWInt = 6'b000001;
    wr(5'd12, 32'h0000_0801);
    tick();
    nchecks++;
    if (bus.intreq !== 1'b0) begin
      nerrors++; $display("FAIL mask_im got %b exp 0", bus.intreq);
    end
    wr(5'd12, 32'h0000_0400);
    nchecks++;
    if (bus.intreq !== 1'b0) begin
      nerrors++; $display("FAIL mask_ie got %b exp 0", bus.intreq);
    end
    wr(5'd12, 32'hFFFF_FFFF);
    bus.A1 = 5'd12;
    #1;
    nchecks++;
    if (bus.DOut !== 32'h0000_FC03) begin
      nerrors++; $display("FAIL sr_fields got %h exp 0000fc03", bus.DOut);
    end
    nchecks++;
    if (bus.intreq !== 1'b0) begin
      nerrors++; $display("FAIL mask_exl got %b exp 0", bus.intreq);
    end
  endtask

  task automatic test_priority();
    wr(5'd12, 32'h0);
    bus.EXLSet = 1'b1; bus.PC = 32'h0000_3000;
    bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_1234;
    tick();
    bus.EXLSet = 1'b0; bus.We = 1'b0;
    bus.A1 = 5'd12;
    #1;
    nchecks++;
    if (bus.EPC !== 32'h0000_3000) begin
      nerrors++; $display("FAIL prio_epc got %h exp 00003000", bus.EPC);
    end
    nchecks++;
    if (bus.DOut !== 32'h0000_0002) begin
      nerrors++; $display("FAIL prio_exl got %h exp 00000002", bus.DOut);
    end
    // EXLClr beats an SR write that tries to set EXL.
    bus.EXLClr = 1'b1; bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403;
    tick();
    bus.EXLClr = 1'b0; bus.We = 1'b0;
    #1;
    nchecks++;
    if (bus.DOut !== 32'h0000_0401) begin
      nerrors++; $display("FAIL prio_clr got %h exp 00000401", bus.DOut);
    end
    bus.HWInt = 6'b000101;
    tick();
    wr(5'd13, 32'hFFFF_FFFF);
    bus.A1 = 5'd13;
    #1;
    nchecks++;
    if (bus.DOut !== 32'h0000_1400) begin
      nerrors++; $display("FAIL cause_ro got %h exp 00001400", bus.DOut);
    end
    wr(5'd15, 32'h0);
    bus.A1 = 5'd15;
    #1;
    nchecks++;
    if (bus.DOut !== 32'h0000_0131) begin
      nerrors++; $display("FAIL prid_ro got %h exp 00000131", bus.DOut);
    end
    wr(5'd14, 32'h0000_1237);
    nchecks++;
    if (bus.EPC !== 32'h0000_1234) begin
      nerrors++; $display("FAIL epc_align got %h exp 00001234", bus.EPC);
    end
  endtask

  task automatic test_random();
    logic [4:0] pick [7];
    pick = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      bus.HWInt  = 6'($urandom);
      bus.EXLSet = ($urandom_range(0, 7) == 0);
      bus.EXLClr = ($urandom_range(0, 7) == 0);
      bus.We     = ($urandom_range(0, 2) == 0);
      bus.A2     = pick[$urandom_range(0, 6)];
      if (bus.A2 == 5'd0) bus.A2 = 5'($urandom);
      bus.DIn    = $urandom;
      bus.PC     = $urandom;
      tick();
      bus.A1 = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 5)] : 5'($urandom);
      #1;
      nchecks++;
      if (bus.intreq !== m_intreq()) begin
        nerrors++; $display("FAIL rnd_intreq n=%0d got %b exp %b", n, bus.intreq, m_intreq());
      end
      nchecks++;
      if (bus.EPC !== m_epc) begin
        nerrors++; $display("FAIL rnd_epc n=%0d got %h exp %h", n, bus.EPC, m_epc);
      end
      nchecks++;
      if (bus.DOut !== m_read(bus.A1)) begin
        nerrors++;
        $display("FAIL rnd_read%0d n=%0d got %h exp %h", bus.A1, n, bus.DOut, m_read(bus.A1));
      end
    end
    rst = 1'b0; bus.We = 1'b0; bus.EXLSet = 1'b0; bus.EXLClr = 1'b0;
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    bus.HWInt = 6'b0;
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    wr(5'd12, 32'h0000_8001);
    for (int i = 0; i < 3; i++) tick();
    nchecks++;
    if (bus.intreq !== 1'b0) begin
      nerrors++; $display("FAIL timer_early got %b exp 0", bus.intreq);
    end
    tick();
    bus.A1 = 5'd13;
    #1;
    nchecks++;
    if (bus.intreq !== 1'b1) begin
      nerrors++; $display("FAIL timer_intreq got %b exp 1", bus.intreq);
    end
    nchecks++;
    if (bus.DOut !== 32'h4000_8000) begin
      nerrors++; $display("FAIL timer_ti got %h exp 40008000", bus.DOut);
    end
    wr(5'd11, 32'd7);
    nchecks++;
    if (bus.DOut !== 32'h0) begin
      nerrors++; $display("FAIL timer_ticlr got %h exp 0", bus.DOut);
    end
    wr(5'd9, 32'hFFFF_FFFF);
    bus.A1 = 5'd9;
    #1;
    nchecks++;
    if (bus.DOut !== 32'hFFFF_FFFF) begin
      nerrors++; $display("FAIL count_load got %h exp ffffffff", bus.DOut);
    end
    tick();
    nchecks++;
    if (bus.DOut !== 32'h0) begin
      nerrors++; $display("FAIL count_wrap got %h exp 0", bus.DOut);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bus.HWInt = 6'b000001;
    wr(5'd12, 32'h0000_0401);
    nchecks++;
    if (bus.intreq !== 1'b1) begin
      nerrors++; $display("FAIL mid_pre_intreq got %b exp 1", bus.intreq);
    end
    bus.EXLSet = 1'b1; bus.PC = 32'h0000_4008;
    tick();
    bus.EXLSet = 1'b0;
    bus.HWInt  = 6'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nchecks++;
    if (bus.intreq !== 1'b0 || bus.EPC !== 32'h0) begin
      nerrors++; $display("FAIL mid_reset got intreq=%b epc=%h exp 0/0", bus.intreq, bus.EPC);
    end
    for (int a = 9; a <= 14; a++) begin
      bus.A1 = 5'(a);
      #1;
      nchecks++;
      if (bus.DOut !== 32'h0) begin
        nerrors++; $display("FAIL mid_reset_read%0d got %h exp 0", a, bus.DOut);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'h0; bus.PC = 32'h0; bus.HWInt = 6'b0;
    bus.We = 1'b0; bus.EXLSet = 1'b0; bus.EXLClr = 1'b0;
    test_reset();
    test_intr();
    test_mask();
    test_priority();
    test_random();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 for the multicycle MIPS core: holds SR, Cause, EPC and PRId, latches the six hardware interrupt lines from the bridge, and raises `intreq` to the controller FSM. It consumes the controller's `EXLSet`/`EXLClr`/`Wen` strobes and supplies `EPC` to the NPC for `eret` and `DOut` to the WD mux for `mfc0`. An optional Count/Compare timer adds an internal interrupt source.

## Interface
- `PRID`, 32'h0000_0131, read-only processor ID returned at register 15.
- `clk  in  1`  core clock; all state changes on posedge.
- `rst  in  1`  reset, synchronous, active-high.
- `A1  in  5`  read register number (instruction rd field, `mfc0`).
- `A2  in  5`  write register number (instruction rd field, `mtc0`).
- `DIn  in  32`  write data (GPR[rt]).
- `PC  in  32`  current PC register value; already the resume address when `EXLSet` pulses.
- `HWInt  in  6`  hardware interrupt lines, level-sensitive.
- `We  in  1`  write enable (controller `Wen`, asserted in S4 of `mtc0`).
- `EXLSet  in  1`  interrupt taken (controller S8).
- `EXLClr  in  1`  `eret` executing (controller S7).
- `intreq  out  1`  interrupt request to controller.
- `EPC  out  32`  return address to NPC.
- `DOut  out  32`  read data for `mfc0`.

## Operation
- Register map:
  - 12 SR: IM = bits[15:10], EXL = bit 1, IE = bit 0; all other bits read 0.
  - 13 Cause: IP = bits[15:10]; TI = bit 30 (macro only); read-only.
  - 14 EPC.
  - 15 PRId, read-only.
  - With macro: 9 Count, 11 Compare.
  - Any other number reads 0; writes to it are dropped.
- `IP <= HWInt` every cycle, plus `IP[15] |= TI` with the macro. No sticky hardware bits.
- `intreq = |(IP & IM) & IE & ~EXL`, computed combinationally from registered state only.
- `EXLSet`: `EXL <= 1` and `EPC <= {PC[31:2],2'b00}`.
- `EXLClr`: `EXL <= 0`.
- `We`: writes `DIn` to SR (bits IM, EXL, IE only) or to EPC (low 2 bits forced 0). Writes to 13 and 15 are ignored.
- `DOut` is a combinational read of register `A1`. `EPC` output is the EPC register.
- Priority:
  - `EXLSet` over `EXLClr` over `We` for the EXL bit.
  - `EXLSet` over `We` for EPC.
  - Non-conflicting fields written in the same cycle all take effect.

## Timing
- Reset values: SR = 0, Cause = 0, EPC = 0, Count = 0, Compare = 0.
  - Outputs after reset: `intreq` = 0, `EPC` = 0.
  - `DOut` after reset: `PRID` when `A1` = 15, otherwise 0.
- `HWInt` rising before edge N → IP set at N → `intreq` high during cycle N..N+1. Total latency: 1 edge.
- `EXLSet` at edge N → `intreq` low from N; the new EPC is visible from N.
- SR write (`We`) at edge N takes effect on `intreq` from N. `mfc0` of a register written the same cycle returns the old value.
- `HWInt` dropping before the controller reaches S8 drops `intreq`; no spurious entry.
- `rst` mid-operation clears all state, including an EXL=1 interrupt in progress.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count increments every cycle, wrapping 0xFFFF_FFFF → 0.
  - When the incremented Count equals Compare, TI <= 1 (sticky).
  - Writing Compare clears TI.
  - Writing Count loads `DIn`; the write beats the increment in the same cycle.
  - TI ORs into IP[15] (HWInt[5] slot, masked by IM[15]).
- `CP0_TIMER_EN` undefined:
  - Registers 9 and 11 read 0 and ignore writes.
  - TI is absent and reads 0.
  - No Count/Compare flops are present.

## Structure
- Shared package `cp0_pkg`:
  - register numbers `CP0_COUNT`=9, `CP0_COMPARE`=11, `CP0_SR`=12, `CP0_CAUSE`=13, `CP0_EPC`=14, `CP0_PRID`=15;
  - field positions for IM, IP, EXL, IE, TI.
- Sub-module `cp0_timer` (Count, Compare, TI), instantiated only under `CP0_TIMER_EN`.

## Test plan
- Reset, read 12/13/14/15 → 0, 0, 0, 0x0000_0131; `intreq` = 0.
- Write SR = 0x0000_0401, pulse HWInt[0] → `intreq` high one edge later. Pulse `EXLSet` with PC = 0x0000_3010 → EPC = 0x3010, `intreq` = 0. Pulse `EXLClr` with HWInt[0] still high → `intreq` = 1.
- SR = 0x0000_0801, HWInt = 6'b000001 → `intreq` stays 0 (masked). IE = 0 with matching IM → `intreq` stays 0.
- Same-cycle `EXLSet` plus `We` to EPC with DIn = 0x1234 and PC = 0x3000 → EPC = 0x3000, EXL = 1. Write to Cause → Cause unchanged.
- Timer (macro on):
  - Compare = 5, Count = 0, SR = 0x0000_8001 → TI and `intreq` rise after 5 increments.
  - Write Compare → TI = 0.
  - Count = 0xFFFF_FFFF wraps to 0.
- `rst` asserted while EXL = 1 and `intreq` high → next cycle all registers 0, `intreq` = 0.
